// File: rtl/mac_tx_arbiter_pkg.sv
// Shared types and sizing constants for the MAC TX source arbiter.
package mac_tx_arbiter_pkg;

  localparam int unsigned N_SYMBOLS            = 4;
  localparam int unsigned W_SYMBOL             = 8;
  localparam int unsigned N_TX_SRC             = 4;
  localparam int unsigned MAX_FRAME_TRANS_DFLT = 512;

  // Beat counter must hold MAX_FRAME_TRANS itself without wrapping.
  function automatic int unsigned arb_cnt_width(input int unsigned max_trans);
    return $clog2(max_trans) + 1;
  endfunction

  localparam int unsigned W_ARB_BEAT_CNT = arb_cnt_width(MAX_FRAME_TRANS_DFLT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_FWD   = 3'b010,
    ST_DRAIN = 3'b100
  } arb_state_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: optional fixed priority for request 0,
// otherwise first requester at or after ptr, wrapping.
module mac_tx_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_IDX = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W_IDX-1:0] ptr,
  input  logic             prio_en,
  output logic [N_REQ-1:0] grant,
  output logic [W_IDX-1:0] idx
);

  logic             found;
  logic [W_IDX-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    if (prio_en && req[0]) begin
      grant[0] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        j = W_IDX'((32'(ptr) + i) % N_REQ);
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = j;
        end
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic AXI-Stream arbiter in front of mac_tx_ctrl; closes underrun and
// oversize frames with a well-formed tlast beat, then drains the source.
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC           = N_TX_SRC,
  parameter int unsigned SRC0_PRIO       = 1,
  parameter int unsigned MAX_FRAME_TRANS = MAX_FRAME_TRANS_DFLT
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset_n,
  input  logic                                    i_clk_en,
  input  logic [N_SRC-1:0]                        s_axis_tvalid,
  input  logic [N_SRC-1:0][N_SYMBOLS-1:0]         s_axis_tkeep,
  input  logic [N_SRC-1:0][N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]                        s_axis_tlast,
  output logic [N_SRC-1:0]                        s_axis_tready,
  output logic                                    m_axis_tvalid,
  output logic [N_SYMBOLS-1:0]                    m_axis_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]           m_axis_tdata,
  output logic                                    m_axis_tlast,
  input  logic                                    m_axis_tready,
  output logic [N_SRC-1:0]                        o_grant,
  output logic                                    o_busy,
  output logic                                    o_underrun,
  output logic                                    o_oversize
);

  localparam int unsigned W_IDX = $clog2(N_SRC);
  localparam int unsigned W_CNT = arb_cnt_width(MAX_FRAME_TRANS);

  arb_state_t       state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [W_IDX-1:0] gidx_q, gidx_d;
  logic [W_IDX-1:0] rr_q, rr_d, rr_next;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             prio_q, prio_d;

  logic [N_SRC-1:0] pick_grant;
  logic [W_IDX-1:0] pick_idx;

  logic                          src_valid, src_last;
  logic [N_SYMBOLS-1:0]          src_keep;
  logic [N_SYMBOLS*W_SYMBOL-1:0] src_data;
  logic                          at_max, underrun, oversize;

  mac_tx_rr_pick #(
    .N_REQ (N_SRC),
    .W_IDX (W_IDX)
  ) u_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_q),
    .prio_en (SRC0_PRIO != 0),
    .grant   (pick_grant),
    .idx     (pick_idx)
  );

  assign src_valid = s_axis_tvalid[gidx_q];
  assign src_last  = s_axis_tlast[gidx_q];
  assign src_keep  = s_axis_tkeep[gidx_q];
  assign src_data  = s_axis_tdata[gidx_q];
  assign at_max    = (cnt_q == W_CNT'(MAX_FRAME_TRANS - 1));
  assign rr_next   = (gidx_q == W_IDX'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
  assign o_grant   = grant_q;
  assign o_busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    prio_d        = prio_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tkeep  = '0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    o_underrun    = 1'b0;
    o_oversize    = 1'b0;
    underrun      = 1'b0;
    oversize      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        first_d = 1'b1;
        if (i_clk_en && |s_axis_tvalid) begin
          state_d = ST_FWD;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          prio_d  = (SRC0_PRIO != 0) && s_axis_tvalid[0];
        end
      end
      ST_FWD: begin
        s_axis_tready[gidx_q] = m_axis_tready & i_clk_en;
        underrun = !first_q && m_axis_tready && i_clk_en && !src_valid;
        oversize = src_valid && at_max && !src_last;
        if (underrun) begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = 1'b1;
          o_underrun    = 1'b1;
          state_d       = ST_DRAIN;
        end else begin
          m_axis_tvalid = src_valid;
          m_axis_tkeep  = src_keep;
          m_axis_tdata  = src_data;
          m_axis_tlast  = src_last | oversize;
          if (src_valid && m_axis_tready && i_clk_en) begin
            cnt_d   = cnt_q + 1'b1;
            first_d = 1'b0;
            if (src_last) begin
              state_d = ST_IDLE;
              grant_d = '0;
              cnt_d   = '0;
              first_d = 1'b1;
              if (!prio_q) rr_d = rr_next;
            end else if (oversize) begin
              o_oversize = 1'b1;
              state_d    = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        s_axis_tready[gidx_q] = i_clk_en;
        if (i_clk_en && src_valid && src_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          if (!prio_q) rr_d = rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      prio_q  <= 1'b0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: source queues feed the DUT, expected
// output beats are queued in the order the arbitration rules dictate.
module tb_mac_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXF = 8;

  logic                   i_clk = 1'b0;
  logic                   i_reset_n;
  logic                   i_clk_en;
  logic [N-1:0]           s_axis_tvalid;
  logic [N-1:0][3:0]      s_axis_tkeep;
  logic [N-1:0][31:0]     s_axis_tdata;
  logic [N-1:0]           s_axis_tlast;
  logic [N-1:0]           s_axis_tready;
  logic                   m_axis_tvalid;
  logic [3:0]             m_axis_tkeep;
  logic [31:0]            m_axis_tdata;
  logic                   m_axis_tlast;
  logic                   m_axis_tready;
  logic [N-1:0]           o_grant;
  logic                   o_busy;
  logic                   o_underrun;
  logic                   o_oversize;

  mac_tx_arbiter #(
    .N_SRC           (N),
    .SRC0_PRIO       (1),
    .MAX_FRAME_TRANS (MAXF)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clk_en      (i_clk_en),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_underrun    (o_underrun),
    .o_oversize    (o_oversize)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0]  data;
    logic [3:0]   keep;
    logic         last;
    logic [N-1:0] grant;
  } exp_t;

  beat_t        src_q [N][$];
  exp_t         sb[$];
  logic [N-1:0] src_en;
  int           rdy_pct, en_pct;
  int           n_cmp, n_err;
  int           ur_cnt, ov_cnt;
  int           src_acc [N];
  logic         last_mvalid, last_busy;
  logic [N-1:0] last_grant, last_sready;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      src_acc[i] = 0;
    end
    sb.delete();
    s_axis_tvalid = '0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    src_en        = '1;
    ur_cnt        = 0;
    ov_cnt        = 0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    clear_all();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // One clock: drive at negedge, sample 1 ns later, book-keep handshakes.
  task automatic step();
    exp_t e;
    @(negedge i_clk);
    i_clk_en      = ($urandom_range(99) < en_pct);
    m_axis_tready = ($urandom_range(99) < rdy_pct);
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i]  = src_q[i][0].data;
        s_axis_tkeep[i]  = src_q[i][0].keep;
        s_axis_tlast[i]  = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i]  = '0;
        s_axis_tkeep[i]  = '0;
        s_axis_tlast[i]  = 1'b0;
      end
    end
    #1;
    last_mvalid = m_axis_tvalid;
    last_grant  = o_grant;
    last_busy   = o_busy;
    last_sready = s_axis_tready;
    if (o_underrun) ur_cnt++;
    if (o_oversize) ov_cnt++;
    for (int i = 0; i < N; i++) begin
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        void'(src_q[i].pop_front());
        src_acc[i]++;
      end
    end
    if (m_axis_tvalid && m_axis_tready && i_clk_en) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data=%h keep=%h last=%b grant=%b, required no beat",
                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_grant);
      end else begin
        e = sb.pop_front();
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_grant} !== e) begin
          n_err++;
          $display("FAIL out_beat: got data=%h keep=%h last=%b grant=%b, required data=%h keep=%h last=%b grant=%b",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_grant, e.data, e.keep, e.last, e.grant);
        end
      end
    end
  endtask

  task automatic run(input int budget, output bit done);
    int n = 0;
    while ((sb.size() != 0 || pending() != 0 || last_busy) && n < budget) begin
      step();
      n++;
    end
    done = (sb.size() == 0 && pending() == 0 && !last_busy);
  endtask

  // Queue nb source beats; the first nexp are expected on m_axis, the last of
  // them with tlast forced when force_last is set.
  task automatic push_frame(input int src, input int nb, input int nexp, input bit force_last);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nb; k++) begin
      b.data = $urandom;
      b.keep = (k == nb - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
      b.last = (k == nb - 1);
      src_q[src].push_back(b);
      if (k < nexp) begin
        e.data  = b.data;
        e.keep  = b.keep;
        e.last  = b.last | (force_last && k == nexp - 1);
        e.grant = N'(1 << src);
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    bit done;
    i_reset_n     = 1'b0;
    i_clk_en      = 1'b1;
    m_axis_tready = 1'b1;
    clear_all();
    s_axis_tvalid = '1;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (s_axis_tready !== '0) begin
      n_err++; $display("FAIL reset_tready: got %b, required 0", s_axis_tready);
    end
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_mvalid: got %b, required 0", m_axis_tvalid);
    end
    n_cmp++;
    if (o_grant !== '0) begin
      n_err++; $display("FAIL reset_grant: got %b, required 0", o_grant);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b, required 0", o_busy);
    end
    n_cmp++;
    if ({o_underrun, o_oversize} !== 2'b00) begin
      n_err++; $display("FAIL reset_pulses: got %b, required 00", {o_underrun, o_oversize});
    end
    @(negedge i_clk);
    clear_all();
    i_reset_n = 1'b1;
    rdy_pct = 100;
    en_pct  = 100;
    push_frame(3, 1, 1, 1'b0);
    step();
    n_cmp++;
    if (last_sready !== '0 || last_mvalid !== 1'b0) begin
      n_err++; $display("FAIL idle_outputs: got tready=%b mvalid=%b, required 0/0", last_sready, last_mvalid);
    end
    run(50, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL single_beat_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
  endtask

  task automatic test_single_frame();
    bit done;
    do_reset();
    rdy_pct = 100;
    en_pct  = 100;
    push_frame(1, 6, 6, 1'b0);
    step();
    n_cmp++;
    if (last_mvalid !== 1'b0 || last_grant !== '0) begin
      n_err++; $display("FAIL bubble: got mvalid=%b grant=%b, required 0/0000", last_mvalid, last_grant);
    end
    step();
    n_cmp++;
    if (last_mvalid !== 1'b1 || last_grant !== 4'b0010) begin
      n_err++; $display("FAIL first_beat: got mvalid=%b grant=%b, required 1/0010", last_mvalid, last_grant);
    end
    run(100, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL single_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
    // pointer now 2: src3 must beat src1
    push_frame(3, 2, 2, 1'b0);
    push_frame(1, 2, 2, 1'b0);
    run(100, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL rr_ptr_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
  endtask

  task automatic test_round_robin();
    bit done;
    do_reset();
    rdy_pct = 70;
    en_pct  = 80;
    for (int f = 0; f < 2; f++)
      for (int s = 1; s < N; s++) push_frame(s, 3, 3, 1'b0);
    run(500, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL rr_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
  endtask

  task automatic test_prio_mid_frame();
    bit done;
    do_reset();
    rdy_pct = 100;
    en_pct  = 100;
    push_frame(2, 5, 5, 1'b0);
    repeat (3) step();
    push_frame(0, 2, 2, 1'b0);
    push_frame(3, 2, 2, 1'b0);
    push_frame(1, 2, 2, 1'b0);
    run(200, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL prio_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
  endtask

  task automatic test_underrun();
    bit   done;
    exp_t e;
    int   n = 0;
    do_reset();
    rdy_pct = 100;
    en_pct  = 100;
    push_frame(2, 10, 5, 1'b0);
    e.data  = '0;
    e.keep  = '0;
    e.last  = 1'b1;
    e.grant = 4'b0100;
    sb.push_back(e);
    while (src_acc[2] < 5 && n < 50) begin
      step();
      n++;
    end
    src_en[2] = 1'b0;
    repeat (3) step();
    src_en[2] = 1'b1;
    run(100, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL underrun_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
    n_cmp++;
    if (ur_cnt != 1 || ov_cnt != 0) begin
      n_err++; $display("FAIL underrun_pulses: got ur=%0d ov=%0d, required 1/0", ur_cnt, ov_cnt);
    end
  endtask

  task automatic test_oversize();
    bit done;
    do_reset();
    rdy_pct = 80;
    en_pct  = 90;
    push_frame(1, 12, MAXF, 1'b1);
    run(300, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL oversize_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
    n_cmp++;
    if (ov_cnt != 1 || ur_cnt != 0) begin
      n_err++; $display("FAIL oversize_pulses: got ov=%0d ur=%0d, required 1/0", ov_cnt, ur_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    do_reset();
    rdy_pct = 100;
    en_pct  = 100;
    push_frame(2, 3, 3, 1'b0);
    run(50, done);
    push_frame(1, 6, 2, 1'b0);
    repeat (3) step();
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || o_grant !== '0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got mvalid=%b tready=%b grant=%b busy=%b, required all 0",
               m_axis_tvalid, s_axis_tready, o_grant, o_busy);
    end
    clear_all();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    push_frame(1, 4, 4, 1'b0);
    push_frame(3, 4, 4, 1'b0);
    rdy_pct = 0;
    repeat (50) step();
    n_cmp++;
    if (last_grant !== 4'b0010) begin
      n_err++; $display("FAIL restart_grant: got %b, required 0010", last_grant);
    end
    rdy_pct = 100;
    run(100, done);
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL stall_timeout: got pending=%0d, required 0", sb.size() + pending());
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    last_busy = 1'b0;
    i_reset_n = 1'b0;
    i_clk_en  = 1'b1;
    m_axis_tready = 1'b0;
    clear_all();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_prio_mid_frame();
    test_underrun();
    test_oversize();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
